// File: rtl/rf_wport_arbiter_pkg.sv
// Shared encodings and widths for the GPR write-port arbiter.
// Optional starvation guard is enabled with RF_WPORT_STARVE_GUARD_EN.
package rf_wport_arbiter_pkg;

  localparam int GPR_AW = 5;
  localparam int GPR_DW = 32;

  localparam logic [GPR_AW-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HELD  = 2'd1,
    ST_FORCE = 2'd2
  } wport_state_e;

  // $0 is hardwired, so a write to it is never architecturally visible.
  function automatic logic is_gpr_write(input logic [GPR_AW-1:0] rw);
    return rw != REG_ZERO;
  endfunction

endpackage

// File: rtl/rf_wport_starve_ctr.sv
// Counts consecutive cycles a buffered result is passed over and flags the
// cycle on which the wait reaches STARVE_LIMIT. Used with RF_WPORT_STARVE_GUARD_EN.
module rf_wport_starve_ctr #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic inc,
  output logic hit
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = inc ? cnt_q + 8'd1 : 8'd0;
    hit   = inc && (cnt_q + 8'd1 == 8'(STARVE_LIMIT));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= 8'd0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Single GPR write port shared by WB and the long-latency result channel,
// with a one-entry skid buffer. Macro RF_WPORT_STARVE_GUARD_EN adds forced drains.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wb_valid,
  input  logic              wb_we,
  input  logic [GPR_AW-1:0] wb_rw,
  input  logic [GPR_DW-1:0] wb_data,
  input  logic              lu_valid,
  input  logic [GPR_AW-1:0] lu_rw,
  input  logic [GPR_DW-1:0] lu_data,
  output logic              lu_ready,
  output logic              wb_stall,
  output logic              rf_we,
  output logic [GPR_AW-1:0] rf_waddr,
  output logic [GPR_DW-1:0] rf_wdata
);

  wport_state_e      state_q, state_d;
  logic [GPR_AW-1:0] buf_rw_q, buf_rw_d;
  logic [GPR_DW-1:0] buf_data_q, buf_data_d;
  logic              rf_we_q, rf_we_d;
  logic [GPR_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [GPR_DW-1:0] rf_wdata_q, rf_wdata_d;

  logic wb_wr;
  logic lu_acc;
  logic lu_keep;

  assign lu_ready = (state_q == ST_EMPTY);

`ifdef RF_WPORT_STARVE_GUARD_EN
  logic starve_inc;
  logic starve_hit;

  assign wb_stall = (state_q == ST_FORCE);
  // A HELD cycle that loses the port to a non-squashing WB write counts as waiting.
  assign starve_inc = (state_q == ST_HELD) && wb_wr && (wb_rw != buf_rw_q);

  rf_wport_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk    (clk),
    .resetn (resetn),
    .inc    (starve_inc),
    .hit    (starve_hit)
  );
`else
  assign wb_stall = 1'b0;
`endif

  assign wb_wr   = wb_valid && wb_we && is_gpr_write(wb_rw) && !wb_stall;
  assign lu_acc  = lu_valid && lu_ready;
  assign lu_keep = lu_acc && is_gpr_write(lu_rw);

  always_comb begin
    state_d    = state_q;
    buf_rw_d   = buf_rw_q;
    buf_data_d = buf_data_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;

    case (state_q)
      ST_EMPTY: begin
        if (wb_wr) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = wb_rw;
          rf_wdata_d = wb_data;
          // Same destination: the younger WB write makes the LU result dead.
          if (lu_keep && (lu_rw != wb_rw)) begin
            buf_rw_d   = lu_rw;
            buf_data_d = lu_data;
            state_d    = ST_HELD;
          end
        end else if (lu_keep) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = lu_rw;
          rf_wdata_d = lu_data;
        end
      end

      ST_HELD: begin
        if (wb_wr) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = wb_rw;
          rf_wdata_d = wb_data;
          if (wb_rw == buf_rw_q) begin
            state_d = ST_EMPTY;
          end
`ifdef RF_WPORT_STARVE_GUARD_EN
          else if (starve_hit) begin
            state_d = ST_FORCE;
          end
`endif
        end else begin
          rf_we_d    = 1'b1;
          rf_waddr_d = buf_rw_q;
          rf_wdata_d = buf_data_q;
          state_d    = ST_EMPTY;
        end
      end

      default: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = buf_rw_q;
        rf_wdata_d = buf_data_q;
        state_d    = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_EMPTY;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= REG_ZERO;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Buffer contents are only meaningful in HELD/FORCE, so they need no reset.
  always_ff @(posedge clk) begin
    buf_rw_q   <= buf_rw_d;
    buf_data_q <= buf_data_d;
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed self-checking bench for rf_wport_arbiter; the starvation scenario
// adapts to whether RF_WPORT_STARVE_GUARD_EN is defined.
module tb_rf_wport_arbiter;

  logic        clk;
  logic        resetn;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rw;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_rw;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        wb_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int checks;
  int errors;

  rf_wport_arbiter #(
    .STARVE_LIMIT(4)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .wb_valid (wb_valid),
    .wb_we    (wb_we),
    .wb_rw    (wb_rw),
    .wb_data  (wb_data),
    .lu_valid (lu_valid),
    .lu_rw    (lu_rw),
    .lu_data  (lu_data),
    .lu_ready (lu_ready),
    .wb_stall (wb_stall),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic v, input logic [4:0] rw, input logic [31:0] d);
    wb_valid = v;
    wb_we    = v;
    wb_rw    = rw;
    wb_data  = d;
  endtask

  task automatic drive_lu(input logic v, input logic [4:0] rw, input logic [31:0] d);
    lu_valid = v;
    lu_rw    = rw;
    lu_data  = d;
  endtask

  task automatic idle();
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_lu(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    step();
    step();
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_rf: we=%b addr=%0d data=%h, want 0/0/0", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (lu_ready !== 1'b1 || wb_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: lu_ready=%b wb_stall=%b, want 1/0", lu_ready, wb_stall);
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_wb_write();
    drive_wb(1'b1, 5'd8, 32'h1234);
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h1234) begin
      errors++;
      $display("FAIL wb_write: we=%b addr=%0d data=%h, want 1/8/00001234", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL wb_write_ready: lu_ready=%b, want 1", lu_ready);
    end
    idle();
    step();
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL wb_write_pulse: we=%b, want 0", rf_we);
    end
  endtask

  task automatic test_lu_bypass();
    drive_lu(1'b1, 5'd5, 32'hAAAA);
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hAAAA) begin
      errors++;
      $display("FAIL lu_bypass: we=%b addr=%0d data=%h, want 1/5/0000aaaa", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL lu_bypass_ready: lu_ready=%b, want 1", lu_ready);
    end
    idle();
    step();
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL lu_bypass_pulse: we=%b, want 0", rf_we);
    end
  endtask

  task automatic test_held_drain();
    drive_wb(1'b1, 5'd3, 32'h3333);
    drive_lu(1'b1, 5'd4, 32'hBEEF);
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h3333) begin
      errors++;
      $display("FAIL held_wb: we=%b addr=%0d data=%h, want 1/3/00003333", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (lu_ready !== 1'b0) begin
      errors++;
      $display("FAIL held_ready: lu_ready=%b, want 0", lu_ready);
    end
    idle();
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'hBEEF) begin
      errors++;
      $display("FAIL held_drain: we=%b addr=%0d data=%h, want 1/4/0000beef", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL held_drain_ready: lu_ready=%b, want 1", lu_ready);
    end
    step();
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL held_drain_pulse: we=%b, want 0", rf_we);
    end
  endtask

  task automatic test_waw_squash();
    drive_wb(1'b1, 5'd2, 32'h22);
    drive_lu(1'b1, 5'd7, 32'h7777);
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || lu_ready !== 1'b0) begin
      errors++;
      $display("FAIL waw_setup: we=%b addr=%0d ready=%b, want 1/2/0", rf_we, rf_waddr, lu_ready);
    end
    drive_lu(1'b0, 5'd0, 32'h0);
    drive_wb(1'b1, 5'd7, 32'h77);
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h77) begin
      errors++;
      $display("FAIL waw_write: we=%b addr=%0d data=%h, want 1/7/00000077", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL waw_ready: lu_ready=%b, want 1", lu_ready);
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (rf_we !== 1'b0) begin
        errors++;
        $display("FAIL waw_no_drain: cycle %0d we=%b addr=%0d, want we=0", i, rf_we, rf_waddr);
      end
    end
  endtask

  task automatic test_same_dest_drop();
    drive_wb(1'b1, 5'd9, 32'h99);
    drive_lu(1'b1, 5'd9, 32'h1111);
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99 || lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL same_dest: we=%b addr=%0d data=%h ready=%b, want 1/9/00000099/1",
               rf_we, rf_waddr, rf_wdata, lu_ready);
    end
    idle();
    step();
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL same_dest_drop: we=%b data=%h, want we=0", rf_we, rf_wdata);
    end
  endtask

  task automatic test_zero_reg();
    drive_lu(1'b1, 5'd0, 32'hDEAD);
    step();
    checks++;
    if (rf_we !== 1'b0 || lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_lu: we=%b ready=%b, want 0/1", rf_we, lu_ready);
    end
    drive_lu(1'b0, 5'd0, 32'h0);
    drive_wb(1'b1, 5'd0, 32'hCAFE);
    step();
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL zero_wb: we=%b, want 0", rf_we);
    end
    idle();
    step();
    checks++;
    if (rf_we !== 1'b0 || lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_after: we=%b ready=%b, want 0/1", rf_we, lu_ready);
    end
  endtask

  task automatic test_reset_discard();
    drive_wb(1'b1, 5'd2, 32'h2);
    drive_lu(1'b1, 5'd6, 32'h6666);
    step();
    idle();
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (rf_we !== 1'b0 || lu_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_discard: cycle %0d we=%b addr=%0d ready=%b, want 0/-/1",
                 i, rf_we, rf_waddr, lu_ready);
      end
    end
  endtask

  task automatic test_starve();
    drive_wb(1'b1, 5'd10, 32'hA0);
    drive_lu(1'b1, 5'd11, 32'hBBBB);
    step();
    drive_lu(1'b0, 5'd0, 32'h0);
`ifdef RF_WPORT_STARVE_GUARD_EN
    // Four waiting HELD cycles, each losing the port to a WB write.
    for (int k = 1; k <= 4; k++) begin
      drive_wb(1'b1, 5'(11 + k), 32'h100 + 32'(k));
      step();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'(11 + k) || wb_stall !== (k == 4)) begin
        errors++;
        $display("FAIL starve_wait: k=%0d we=%b addr=%0d stall=%b, want 1/%0d/%b",
                 k, rf_we, rf_waddr, wb_stall, 11 + k, (k == 4));
      end
    end
    drive_wb(1'b1, 5'd20, 32'h2020);
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'hBBBB || wb_stall !== 1'b0) begin
      errors++;
      $display("FAIL starve_force: we=%b addr=%0d data=%h stall=%b, want 1/11/0000bbbb/0",
               rf_we, rf_waddr, rf_wdata, wb_stall);
    end
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd20 || rf_wdata !== 32'h2020 || lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL starve_retry: we=%b addr=%0d data=%h ready=%b, want 1/20/00002020/1",
               rf_we, rf_waddr, rf_wdata, lu_ready);
    end
    idle();
    step();
`else
    for (int k = 1; k <= 6; k++) begin
      drive_wb(1'b1, 5'(11 + k), 32'h100 + 32'(k));
      step();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'(11 + k) || wb_stall !== 1'b0 || lu_ready !== 1'b0) begin
        errors++;
        $display("FAIL starve_wait: k=%0d we=%b addr=%0d stall=%b ready=%b, want 1/%0d/0/0",
                 k, rf_we, rf_waddr, wb_stall, lu_ready, 11 + k);
      end
    end
    idle();
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'hBBBB || lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL starve_drain: we=%b addr=%0d data=%h ready=%b, want 1/11/0000bbbb/1",
               rf_we, rf_waddr, rf_wdata, lu_ready);
    end
    step();
`endif
    checks++;
    if (rf_we !== 1'b0 || wb_stall !== 1'b0) begin
      errors++;
      $display("FAIL starve_end: we=%b stall=%b, want 0/0", rf_we, wb_stall);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b1;
    idle();
    #1;
    test_reset();
    test_wb_write();
    test_lu_bypass();
    test_held_drain();
    test_waw_squash();
    test_same_dest_drop();
    test_zero_reg();
    test_reset_discard();
    test_starve();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

Arbitrates the single GPR register-file write port between the in-order pipeline writeback stage (destination already chosen as $31/rt/rd by the writeback select logic) and the long-latency unit result channel (MUL/DIV-to-GPR, MFC0). The block holds one pending long-latency result in a skid buffer and drains it into idle writeback slots. It squashes stale results on write-after-write hazards. Optionally, it forces a one-cycle pipeline stall when the pending result starves. Sits between the WB stage and the register file, with registered write outputs.

## Interface
- STARVE_LIMIT, 8, cycles a buffered result may wait before a forced drain (1..255)
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- wb_valid  in  1  writeback stage holds a valid instruction
- wb_we  in  1  instruction writes a GPR
- wb_rw  in  5  destination register (0/rt/rd/31 already resolved)
- wb_data  in  32  writeback data
- lu_valid  in  1  long-latency result offered
- lu_rw  in  5  result destination register
- lu_data  in  32  result data
- lu_ready  out  1  result accepted this cycle when lu_valid & lu_ready
- wb_stall  out  1  pipeline must hold WB this cycle
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  32  register-file write data (registered)

## Operation
- Terms: wb_wr = wb_valid & wb_we & (wb_rw != 0) & ~wb_stall; lu_acc = lu_valid & lu_ready.
- States: EMPTY (buffer free), HELD (buffer holds buf_rw/buf_data), FORCE (HELD plus forced drain).
- lu_ready = 1 in EMPTY only; combinational from state.
- Per-cycle priority:
  - In FORCE, write the buffer, then go to EMPTY.
  - Otherwise, if wb_wr, write the WB data.
  - Otherwise, in HELD, write the buffer, then go to EMPTY.
  - Otherwise, if lu_acc and lu_rw != 0, write the LU data directly (bypass; state stays EMPTY).
- In EMPTY, if wb_wr and lu_acc both occur:
  - If lu_rw == wb_rw, drop the LU result; the younger WB write wins.
  - Otherwise, load the LU result into the buffer and go to HELD.
- WAW squash: in HELD with wb_wr and wb_rw == buf_rw, discard the buffer and go to EMPTY.
- lu_acc with lu_rw == 0 is accepted and dropped; state unchanged.
- Writes to $0 never assert rf_we.
- In FORCE, WB inputs are ignored; the pipeline retries the same instruction next cycle.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, state EMPTY, starve counter 0. Consequently lu_ready=1 and wb_stall=0 during reset.
- Reset asserted mid-operation discards the buffered result.
- Latency: one cycle from the selected input to rf_we/rf_waddr/rf_wdata.
- rf_we is high for exactly one cycle per write.
- wb_stall is combinational from state: high exactly in FORCE, one cycle per forced drain.
- The pipeline must forward from rf_* during the one-cycle write latency; this block provides no bypass outputs.

## Configuration
- Macro: RF_WPORT_STARVE_GUARD_EN.
- Defined:
  - The counter increments each cycle HELD is not drained and clears on leaving HELD.
  - On reaching STARVE_LIMIT, the next state is FORCE.
- Undefined:
  - No counter and no FORCE state; wb_stall is tied 0.
  - A buffered result waits indefinitely for an idle WB slot; STARVE_LIMIT is unused.

## Structure
- Shared package/header holds:
  - State encodings (EMPTY=2'd0, HELD=2'd1, FORCE=2'd2)
  - REG_ZERO=5'd0
  - GPR address width 5 and data width 32
- One sub-module, rf_wport_starve_ctr: counter plus limit compare; instantiated only under RF_WPORT_STARVE_GUARD_EN.

## Test plan
- Reset, then wb_valid=1, wb_we=1, wb_rw=8, wb_data=32'h1234 → next cycle rf_we=1, rf_waddr=8, rf_wdata=32'h1234; lu_ready=1 throughout.
- WB idle, lu_valid=1, lu_rw=5, lu_data=32'hAAAA → next cycle rf_we=1, rf_waddr=5; state remains EMPTY.
- WB writes r3 while lu offers r4=32'hBEEF → r3 written; buffer HELD, lu_ready=0. First WB-idle cycle → r4=32'hBEEF written one cycle later, lu_ready back to 1.
- HELD with buf_rw=7, then WB writes r7=32'h77 → r7=32'h77 written; buffer discarded, never written; lu_ready=1 next cycle.
- lu offers r0 → accepted; no rf_we ever. WB writes r0 → no rf_we.
- With RF_WPORT_STARVE_GUARD_EN and STARVE_LIMIT=4, continuous WB writes while HELD:
  - wb_stall=1 for one cycle after 4 waiting cycles, and the buffer is written that cycle.
  - The WB instruction is written the following cycle.
  - Without the macro, wb_stall stays 0.
